controlador_estados_param: RTL



---
 rtl/controlador_estados_param_pkg.sv | 31 +++
 rtl/controlador_estados_param_if.sv | 26 ++
 rtl/controlador_estados_param_tick_divider.sv | 31 +++
 rtl/controlador_estados_param.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/controlador_estados_param_pkg.sv
// Shared types and helpers for the pet state controller.
// State codes are one-hot with INTRO as the all-zero code.
package controlador_estados_param_pkg;

  typedef enum logic [5:0] {
    INTRO      = 6'b000000,
    IDLE       = 6'b000001,
    DORMINDO   = 6'b000010,
    COMENDO    = 6'b000100,
    DANDO_AULA = 6'b001000,
    MORTO      = 6'b010000,
    ALERTA     = 6'b100000
  } estado_t;

  localparam int FOME       = 0;
  localparam int FELICIDADE = 1;
  localparam int SONO       = 2;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/controlador_estados_param_if.sv
// Button, stat and status bundle between the
// debouncers/stats blocks and the pet state controller.
interface controlador_estados_param_if #(
  parameter int N_STATS = 3,
  parameter int STAT_W  = 8
);
  logic                      b1;
  logic                      b2;
  logic                      b1_hold;
  logic                      b2_hold;
  logic [N_STATS*STAT_W-1:0] stats;
  logic [5:0]                estado;
  logic                      tick;
  logic [N_STATS-1:0]        low_mask;
  logic [N_STATS-1:0]        zero_mask;

  modport master (
    output b1, b2, b1_hold, b2_hold, stats,
    input  estado, tick, low_mask, zero_mask
  );

  modport slave (
    input  b1, b2, b1_hold, b2_hold, stats,
    output estado, tick, low_mask, zero_mask
  );
endinterface

// File: rtl/controlador_estados_param_tick_divider.sv
// Free-running 0..TICK_DIV-1 counter; flags its last cycle.
// Shared with the stats decay block.
module controlador_estados_param_tick_divider
  import controlador_estados_param_pkg::*;
#(
  parameter int TICK_DIV = 4194304
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clr,
  output logic last
);

  localparam int DW = clog2(TICK_DIV);
  localparam logic [DW-1:0] LAST_V = DW'(TICK_DIV - 1);

  logic [DW-1:0] cnt;

  assign last = (cnt == LAST_V);

  always_ff @(posedge clk) begin
    if (!rst_n || sync_clr) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/controlador_estados_param.sv
// Pet state controller: one decision per tick from
// latched presses and live stats, plus hold-to-restart.
module controlador_estados_param
  import controlador_estados_param_pkg::*;
#(
  parameter int STAT_W      = 8,
  parameter int N_STATS     = 3,
  parameter int TICK_DIV    = 4194304,
  parameter int HOLD_CYCLES = 4194303,
  parameter int ACT_TICKS   = 8,
  parameter int LOW_THRESH  = 32
) (
  input logic clk,
  input logic rst_n,
  controlador_estados_param_if.slave bus
);

  localparam int HW  = clog2(HOLD_CYCLES + 1);
  localparam int AW0 = clog2(ACT_TICKS + 1);
  localparam int AW  = (AW0 < 1) ? 1 : AW0;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);
  localparam logic [AW-1:0] ACT_LD   = AW'(ACT_TICKS);
  localparam logic [AW-1:0] ACT_ONE  = AW'(1);

  estado_t            st;
  estado_t            rest;
  logic               tick_q;
  logic [N_STATS-1:0] low_q;
  logic [N_STATS-1:0] zero_q;
  logic [N_STATS-1:0] low_live;
  logic [N_STATS-1:0] zero_live;
  logic [AW-1:0]      act_cnt;
  logic [HW-1:0]      hold_cnt;
  logic               b1_l;
  logic               b2_l;
  logic               p1;
  logic               p2;
  logic               last;
  logic               hold_both;
  logic               hold_fire;
  logic               hold_sat;

  always_comb begin
    low_live  = '0;
    zero_live = '0;
    for (int i = 0; i < N_STATS; i++) begin
      low_live[i] =
        int'(bus.stats[i*STAT_W +: STAT_W]) < LOW_THRESH;
      zero_live[i] =
        (bus.stats[i*STAT_W +: STAT_W] == '0);
    end
  end

  assign rest      = (|low_live) ? ALERTA : IDLE;
  assign p1        = b1_l | bus.b1;
  assign p2        = b2_l | bus.b2;
  assign hold_both = bus.b1_hold & bus.b2_hold;
  assign hold_sat  = (hold_cnt == HOLD_MAX);
  assign hold_fire = hold_both && (hold_cnt == HOLD_PRE);

  controlador_estados_param_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (hold_fire),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= INTRO;
      tick_q   <= 1'b0;
      low_q    <= '0;
      zero_q   <= '0;
      act_cnt  <= '0;
      hold_cnt <= '0;
      b1_l     <= 1'b0;
      b2_l     <= 1'b0;
    end else begin
      tick_q <= last;
      low_q  <= low_live;
      zero_q <= zero_live;

      if (!hold_both) hold_cnt <= '0;
      else if (!hold_sat) hold_cnt <= hold_cnt + 1'b1;

      // Restart hold outranks any decision on this edge
      if (hold_fire || hold_sat) begin
        st   <= INTRO;
        b1_l <= 1'b0;
        b2_l <= 1'b0;
        if (hold_fire) act_cnt <= '0;
      end else if (last) begin
        b1_l <= 1'b0;
        b2_l <= 1'b0;
        if (st == MORTO) begin
          st <= MORTO;
        end else if (st != INTRO && |zero_live) begin
          st <= MORTO;
        end else begin
          unique case (st)
            INTRO: begin
              if (p1 | p2) st <= rest;
            end
            IDLE, ALERTA: begin
              unique case ({p1, p2})
                2'b10: begin
                  st      <= COMENDO;
                  act_cnt <= ACT_LD;
                end
                2'b01: begin
                  st      <= DORMINDO;
                  act_cnt <= ACT_LD;
                end
                2'b11: begin
                  st      <= DANDO_AULA;
                  act_cnt <= ACT_LD;
                end
                default: st <= rest;
              endcase
            end
            COMENDO, DORMINDO, DANDO_AULA: begin
              if (p1 | p2) begin
                st <= rest;
              end else if (ACT_TICKS != 0
                           && act_cnt == ACT_ONE) begin
                st <= rest;
              end else if (act_cnt != '0) begin
                act_cnt <= act_cnt - 1'b1;
              end
            end
            default: st <= INTRO;
          endcase
        end
      end else begin
        b1_l <= b1_l | bus.b1;
        b2_l <= b2_l | bus.b2;
      end
    end
  end

  assign bus.estado    = st;
  assign bus.tick      = tick_q;
  assign bus.low_mask  = low_q;
  assign bus.zero_mask = zero_q;

endmodule
